// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus width, default read data and splitter FSM states.
package apb_pkg;
    localparam int BUS_W = 32;
    localparam logic [BUS_W-1:0] DEFAULT_RDATA = 32'hDEADBEEF;
    typedef enum logic {IDLE, ACCESS} state_t;
endpackage

// File: rtl/apb_timeout.sv
// apb_timeout: wait-state counter that aborts a stalled slave access.
module apb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic ready,
    input  logic leave,
    output logic timeout,
    output logic abort
);
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] cnt;
    logic abort_q;
    // a slave that answers in the limit cycle still wins
    assign timeout = (TIMEOUT_CYCLES != 0) && active && !ready && cnt == LIMIT;
    assign abort = abort_q | timeout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            if (start)
                cnt <= '0;
            else if (active && !ready && cnt != LIMIT)
                cnt <= cnt + 1'b1;
            abort_q <= leave ? 1'b0 : abort_q | timeout;
        end
    end
endmodule

// File: rtl/apb_splitter.sv
// apb_splitter: one APB master fanned out to NUM_SLAVES slaves by a PADDR field,
// answering unmapped, stalled and malformed transfers itself with an error.
module apb_splitter import apb_pkg::*; #(
    parameter int NUM_SLAVES = 4,
    parameter int DEC_LSB = 16,
    parameter int DEC_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [BUS_W-1:0] DEFAULT_RDATA = apb_pkg::DEFAULT_RDATA
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [BUS_W-1:0]            PADDR,
    input  logic [BUS_W-1:0]            PWDATA,
    output logic                        PREADY,
    output logic [BUS_W-1:0]            PRDATA,
    output logic                        PSLVERR,
    output logic [NUM_SLAVES-1:0]       PSEL_S,
    output logic                        PENABLE_S,
    output logic                        PWRITE_S,
    output logic [BUS_W-1:0]            PADDR_S,
    output logic [BUS_W-1:0]            PWDATA_S,
    input  logic [NUM_SLAVES-1:0]       PREADY_S,
    input  logic [NUM_SLAVES*BUS_W-1:0] PRDATA_S,
    input  logic [NUM_SLAVES-1:0]       PSLVERR_S,
    output logic [7:0]                  err_count
);
    state_t state;
    logic [DEC_WIDTH-1:0] idx, sel_idx;
    logic hit, sel_hit, sel_ready, sel_err, in_access, setup, violation, timeout, abort;
    logic [BUS_W-1:0] sel_rdata;
    assign idx = PADDR[DEC_LSB +: DEC_WIDTH];
    assign hit = 32'(idx) < NUM_SLAVES;
    assign in_access = state == ACCESS;
    assign setup = !in_access && PSEL && !PENABLE;
    assign violation = !in_access && PSEL && PENABLE;
    assign PENABLE_S = PENABLE;
    assign PWRITE_S = PWRITE;
    assign PADDR_S = PADDR;
    assign PWDATA_S = PWDATA;
    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++)
            PSEL_S[i] = PSEL && hit && idx == DEC_WIDTH'(i) && !abort && !violation;
    end
    always_comb begin
        sel_ready = 1'b0;
        sel_err = 1'b0;
        sel_rdata = DEFAULT_RDATA;
        for (int i = 0; i < NUM_SLAVES; i++)
            if (sel_idx == DEC_WIDTH'(i)) begin
                sel_ready = PREADY_S[i];
                sel_err = PSLVERR_S[i];
                sel_rdata = PRDATA_S[BUS_W*i +: BUS_W];
            end
    end
    // the splitter answers itself unless a mapped slave is live in ACCESS
    always_comb begin
        PREADY = 1'b1;
        PSLVERR = violation;
        PRDATA = DEFAULT_RDATA;
        if (in_access && PSEL) begin
            PREADY = (sel_hit && !abort) ? sel_ready : 1'b1;
            PSLVERR = (sel_hit && !abort) ? sel_err : 1'b1;
            PRDATA = (sel_hit && !abort) ? sel_rdata : DEFAULT_RDATA;
        end
    end
    apb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(PCLK),
        .rst_n(PRESETn),
        .start(setup),
        .active(in_access && PSEL && sel_hit),
        .ready(sel_ready),
        .leave(in_access && PREADY),
        .timeout(timeout),
        .abort(abort)
    );
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            sel_idx <= '0;
            sel_hit <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (setup) begin
                state <= ACCESS;
                sel_idx <= idx;
                sel_hit <= hit;
            end else if (in_access && PREADY) begin
                state <= IDLE;
            end
            if (PREADY && PSLVERR && PSEL && PENABLE && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_apb_splitter.sv
// tb_apb_splitter: directed and random transfers checked against a transfer-level model.
module tb_apb_splitter;
    localparam int NS = 4;
    localparam int TO = 4;
    localparam logic [31:0] DEF = 32'hDEADBEEF;

    logic PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic PREADY, PSLVERR, PENABLE_S, PWRITE_S;
    logic [31:0] PRDATA, PADDR_S, PWDATA_S;
    logic [NS-1:0] PSEL_S;
    logic [NS-1:0] PREADY_S = '0, PSLVERR_S = '0;
    logic [NS*32-1:0] PRDATA_S = '0;
    logic [7:0] err_count;

    int passed = 0, total = 0, model_err = 0;

    apb_splitter #(.NUM_SLAVES(NS), .DEC_LSB(16), .DEC_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .PSEL_S(PSEL_S), .PENABLE_S(PENABLE_S), .PWRITE_S(PWRITE_S), .PADDR_S(PADDR_S),
        .PWDATA_S(PWDATA_S), .PREADY_S(PREADY_S), .PRDATA_S(PRDATA_S), .PSLVERR_S(PSLVERR_S),
        .err_count(err_count)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_cnt();
        return model_err > 255 ? 255 : model_err;
    endfunction

    task automatic scramble();
        for (int s = 0; s < NS; s++) PRDATA_S[32*s +: 32] = $urandom;
    endtask

    // one complete transfer; the model decides the completion cycle and response
    task automatic xfer(input logic [31:0] addr, input logic wr, input int waits,
                        input logic [31:0] rdata, input logic serr);
        int idx, done;
        bit mapped, tmo, e;
        logic [NS-1:0] onehot;
        logic [31:0] wd;
        idx = int'((addr >> 16) & 32'hFF);
        mapped = idx < NS;
        tmo = mapped && waits > TO;
        done = !mapped ? 1 : (tmo ? TO + 1 : waits + 1);
        onehot = mapped ? NS'(1 << idx) : '0;
        wd = $urandom;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        PREADY_S = '0; PSLVERR_S = '0; scramble();
        #1;
        check("setup_psel_s", 32'(PSEL_S), 32'(onehot));
        check("setup_pslverr", 32'(PSLVERR), 0);
        check("fwd_paddr", PADDR_S, addr);
        check("fwd_pwdata", PWDATA_S, wd);
        check("fwd_pwrite", 32'(PWRITE_S), 32'(wr));
        for (int k = 1; k <= done; k++) begin
            @(negedge PCLK);
            PENABLE = 1'b1;
            PREADY_S = (mapped && k > waits) ? onehot : '0;
            PSLVERR_S = serr ? onehot : '0;
            scramble();
            if (mapped) PRDATA_S[32*idx +: 32] = rdata;
            #1;
            check("pready", 32'(PREADY), 32'(k == done));
            check("fwd_penable", 32'(PENABLE_S), 1);
            if (k == done) begin
                e = !mapped || tmo || serr;
                check("prdata", PRDATA, (!mapped || tmo) ? DEF : rdata);
                check("pslverr", 32'(PSLVERR), 32'(e));
                check("done_psel_s", 32'(PSEL_S), tmo ? 0 : 32'(onehot));
                if (e) model_err++;
            end
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PREADY_S = '0; PSLVERR_S = '0;
        #1;
        check("err_count", 32'(err_count), exp_cnt());
    endtask

    initial begin
        logic [31:0] a;
        int ri;
        // reset state, and decode visible while reset is held
        @(negedge PCLK);
        #1;
        check("rst_err_count", 32'(err_count), 0);
        check("rst_pready", 32'(PREADY), 1);
        check("rst_pslverr", 32'(PSLVERR), 0);
        check("rst_prdata", PRDATA, DEF);
        check("rst_psel_s", 32'(PSEL_S), 0);
        PSEL = 1'b1; PADDR = 32'h0003_0000;
        #1;
        check("rst_decode", 32'(PSEL_S), 32'h8);
        PSEL = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;

        xfer(32'h0002_0010, 1'b1, 2, 32'hA5A5_0002, 1'b0);
        xfer(32'h0007_0000, 1'b0, 0, 32'h0, 1'b0);
        check("unmapped_cnt", 32'(err_count), 1);
        xfer(32'h0001_0000, 1'b0, 100, 32'h1111_1111, 1'b0);
        xfer(32'h0000_0000, 1'b0, 4, 32'h0000_1234, 1'b0);
        xfer(32'h0003_0040, 1'b0, 1, 32'h3333_0000, 1'b1);

        // ACCESS-phase signalling without a SETUP
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h0000_0000;
        #1;
        check("viol_pready", 32'(PREADY), 1);
        check("viol_pslverr", 32'(PSLVERR), 1);
        check("viol_psel_s", 32'(PSEL_S), 0);
        check("viol_prdata", PRDATA, DEF);
        model_err++;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        check("viol_cnt", 32'(err_count), exp_cnt());
        xfer(32'h0000_0100, 1'b1, 0, 32'h0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            ri = $urandom_range(0, 7);
            a = {8'h00, 8'(ri), 16'($urandom)};
            xfer(a, 1'($urandom), $urandom_range(0, 6), $urandom, $urandom_range(0, 3) == 0);
        end

        // master abandons ACCESS
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0002_0000; PREADY_S = '0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("drop_wait", 32'(PREADY), 0);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        #1;
        check("drop_pready", 32'(PREADY), 1);
        check("drop_pslverr", 32'(PSLVERR), 0);
        xfer(32'h0002_0000, 1'b0, 1, 32'h2222_2222, 1'b0);

        for (int n = 0; n < 260; n++) xfer(32'h00FF_0000, 1'b0, 0, 32'h0, 1'b0);
        check("sat_cnt", 32'(err_count), 255);
        xfer(32'h0080_0000, 1'b1, 0, 32'h0, 1'b0);
        check("sat_hold", 32'(err_count), 255);

        // asynchronous reset in the middle of a stalled ACCESS
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0001_0000; PREADY_S = '0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        check("mid_wait", 32'(PREADY), 0);
        PRESETn = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(err_count), 0);
        check("mid_rst_idle_pready", 32'(PREADY), 1);
        check("mid_rst_idle_pslverr", 32'(PSLVERR), 1);
        check("mid_rst_psel_s", 32'(PSEL_S), 0);
        model_err = 0;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(32'h0001_0000, 1'b0, 3, 32'h0BAD_F00D, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
